// File: rtl/tt_um_hoene_manchester_pkg.sv
// Shared definitions for the Manchester link: frame states, idle line level,
// and the coding rule. The decoder side imports this package too.
package tt_um_hoene_manchester_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    GAP      = 2'd3
  } state_t;

  localparam logic LINE_IDLE = 1'b0;

  // Line level for one half of a bit: '1' is low then high, '0' is high then low.
  function automatic logic half_level(input logic bit_val, input logic second_half);
    return bit_val ? second_half : ~second_half;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tt_um_hoene_manchester_if.sv
// Word handshake into the encoder.
// A transfer happens on a rising edge where in_valid && in_ready are both high.
// The source holds in_data/in_valid stable while in_ready is low; in_ready does
// not depend on in_valid.
interface tt_um_hoene_manchester_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/tt_um_hoene_halfbit_timer.sv
// Half-bit timer: counts HALF_PERIOD cycles per half and tracks which half of
// the bit is on the line. Held at the start of a bit while restart is high.
module tt_um_hoene_halfbit_timer #(
  parameter int HALF_PERIOD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic half_tick,
  output logic second_half
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [CW-1:0] cnt;

  assign half_tick = (cnt == CW'(HALF_PERIOD - 1));

  // Count within a half, wrap at its last cycle and flip the half flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      second_half <= 1'b0;
    end else if (restart) begin
      cnt         <= '0;
      second_half <= 1'b0;
    end else if (half_tick) begin
      cnt         <= '0;
      second_half <= ~second_half;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tt_um_hoene_manchester_encoder.sv
// Manchester transmitter: a one-word holding register feeds a frame FSM that
// sends preamble '1's, the payload MSB first, then a low gap.
module tt_um_hoene_manchester_encoder
  import tt_um_hoene_manchester_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int HALF_PERIOD   = 8,
  parameter int PREAMBLE_BITS = 4,
  parameter int GAP_BITS      = 2
) (
  input  logic   clk,
  input  logic   rst,
  tt_um_hoene_manchester_if.slave bus,
  output logic   out,
  output logic   busy,
  output logic   frame_done,
  output state_t dbg_state
);

  localparam int BIT_MAX = max3(PREAMBLE_BITS, DATA_WIDTH, GAP_BITS);
  localparam int BCW     = $clog2(BIT_MAX + 1);

  state_t                state_q, state_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shifter_q, shifter_d;
  logic                  out_q, out_d;
  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  load;
  logic                  accept;
  logic                  half_tick, second_half, bit_end;

  assign bus.in_ready = ~hold_valid;
  assign accept       = bus.in_valid & ~hold_valid;
  assign bit_end      = half_tick & second_half;
  assign out          = out_q;
  assign busy         = (state_q != IDLE);
  assign dbg_state    = state_q;

  // Timer idles at the start of a bit until a frame begins; inside a frame it
  // free-runs, so bit and state boundaries fall on its wraps.
  tt_um_hoene_halfbit_timer #(.HALF_PERIOD(HALF_PERIOD)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .restart     (state_q == IDLE),
    .half_tick   (half_tick),
    .second_half (second_half)
  );

  // One-entry holding register; refilled independently of the frame state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= bus.in_data;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

  // Frame state, bit counter, payload shifter and registered line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shifter_q <= '0;
      out_q     <= LINE_IDLE;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shifter_q <= shifter_d;
      out_q     <= out_d;
    end
  end

  // Next state and next line level; bit_cnt holds the bits left after the current one.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shifter_d  = shifter_q;
    out_d      = out_q;
    load       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        out_d = LINE_IDLE;
        load  = hold_valid;
      end
      PREAMBLE: begin
        if (half_tick && !second_half) begin
          out_d = half_level(1'b1, 1'b1);
        end else if (bit_end) begin
          if (bit_cnt_q == '0) begin
            state_d   = DATA;
            bit_cnt_d = BCW'(DATA_WIDTH - 1);
            out_d     = half_level(shifter_q[DATA_WIDTH-1], 1'b0);
          end else begin
            bit_cnt_d = bit_cnt_q - BCW'(1);
            out_d     = half_level(1'b1, 1'b0);
          end
        end
      end
      DATA: begin
        if (half_tick && !second_half) begin
          out_d = half_level(shifter_q[DATA_WIDTH-1], 1'b1);
        end else if (bit_end) begin
          if (bit_cnt_q == '0) begin
            state_d   = GAP;
            bit_cnt_d = BCW'(GAP_BITS - 1);
            out_d     = LINE_IDLE;
          end else begin
            shifter_d = shifter_q << 1;
            bit_cnt_d = bit_cnt_q - BCW'(1);
            out_d     = half_level(shifter_q[DATA_WIDTH-2], 1'b0);
          end
        end
      end
      GAP: begin
        out_d = LINE_IDLE;
        if (bit_end) begin
          if (bit_cnt_q == '0) begin
            frame_done = 1'b1;
            if (hold_valid) load = 1'b1;
            else            state_d = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q - BCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Frame start overrides: the first preamble half goes out on the same edge.
    if (load) begin
      state_d   = PREAMBLE;
      bit_cnt_d = BCW'(PREAMBLE_BITS - 1);
      shifter_d = hold_data;
      out_d     = half_level(1'b1, 1'b0);
    end
  end

endmodule

// File: tb/tb_tt_um_hoene_manchester_encoder.sv
// Bench for the Manchester encoder at HALF_PERIOD=2: directed vector table plus
// hand-written multi-frame and reset sequences, with a frame monitor that
// compares every completed frame to a bit-level line model.
module tb_tt_um_hoene_manchester_encoder;
  import tt_um_hoene_manchester_pkg::*;

  localparam int HP        = 2;
  localparam int FRAME_CYC = (4 + 32 + 2) * 2 * HP;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  tt_um_hoene_manchester_if #(.DATA_WIDTH(32)) bus ();
  logic   out, busy, frame_done;
  state_t dbg_state;

  tt_um_hoene_manchester_encoder #(
    .DATA_WIDTH(32), .HALF_PERIOD(HP), .PREAMBLE_BITS(4), .GAP_BITS(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .out        (out),
    .busy       (busy),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic        cap_q[$];
  int          fd_log[$];
  int          frames_seen = 0;
  logic [31:0] mon_w;
  int          mon_bad;

  function automatic logic exp_out(input logic [31:0] w, input int k);
    int   b;
    logic sec, v;
    b   = k / (2 * HP);
    sec = ((k / HP) % 2) == 1;
    if (b >= 36) return 1'b0;
    v = (b < 4) ? 1'b1 : w[31 - (b - 4)];
    return v ? sec : ~sec;
  endfunction

  always @(posedge rst) cap_q.delete();

  always @(negedge clk) begin
    if (!rst) begin
      if (busy) begin
        cap_q.push_back(out);
        if (frame_done) begin
          fd_log.push_back(cyc);
          check("frame_len", 64'(cap_q.size()), 64'(FRAME_CYC));
          if (exp_q.size() == 0) begin
            check("frame_expected", 64'd0, 64'd1);
          end else begin
            mon_w   = exp_q.pop_front();
            mon_bad = 0;
            for (int k = 0; k < cap_q.size(); k++)
              if (cap_q[k] !== exp_out(mon_w, k)) mon_bad++;
            check("frame_bits", 64'(mon_bad), 64'd0);
          end
          cap_q.delete();
          frames_seen++;
        end
      end else begin
        check("idle_out", 64'(out), 64'd0);
        check("idle_no_done", 64'(frame_done), 64'd0);
        if (cap_q.size() != 0) begin
          check("frame_truncated", 64'(cap_q.size()), 64'd0);
          cap_q.delete();
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic offer(input logic [31:0] w, output int acc);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("offer_timeout", 64'd1, 64'd0);
    else           exp_q.push_back(w);
    @(negedge clk);
    acc          = cyc;
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_seen < n && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("frames_seen", 64'(frames_seen), 64'(n));
  endtask

  task automatic reset_logs();
    fd_log.delete();
    frames_seen = 0;
  endtask

  typedef struct {
    logic [31:0] data;
    logic [31:0] exp_head;
  } vec_t;

  vec_t vecs[4];
  int   a0, a1, a2, fd_at, bad_idle;
  logic [31:0] head;

  initial begin
    vecs[0] = '{32'hA500_0001, 32'h3333_3C3C};
    vecs[1] = '{32'hFFFF_FFFF, 32'h3333_3333};
    vecs[2] = '{32'h0000_0000, 32'h3333_CCCC};
    vecs[3] = '{32'h5A5A_5A5A, 32'h3333_C3C3};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_out", 64'(out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    #1 rst = 1'b0;

    // Idle for 100 cycles.
    bad_idle = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) bad_idle++;
    end
    check("idle_100", 64'(bad_idle), 64'd0);

    // Table of single words: latency, ready drop, preamble/data head, frame_done timing.
    for (int v = 0; v < 4; v++) begin
      reset_logs();
      offer(vecs[v].data, a0);
      check("pre_busy", 64'(busy), 64'd0);
      check("ready_drop", 64'(bus.in_ready), 64'd0);
      head  = '0;
      fd_at = -1;
      for (int k = 1; k <= FRAME_CYC; k++) begin
        @(negedge clk);
        if (k == 1) check("busy_rise", 64'(busy), 64'd1);
        if (k == 2) check("ready_back", 64'(bus.in_ready), 64'd1);
        if (k <= 32) head = {head[30:0], out};
        if (frame_done && fd_at < 0) fd_at = k;
      end
      check("head", 64'(head), 64'(vecs[v].exp_head));
      check("done_at", 64'(fd_at), 64'(FRAME_CYC));
      @(negedge clk);
      check("busy_fall", 64'(busy), 64'd0);
      check("out_after", 64'(out), 64'd0);
    end

    // Back-to-back: second word offered during the first frame's DATA.
    reset_logs();
    offer(32'hFFFF_FFFF, a0);
    wait_until(a0 + 60);
    offer(32'h0000_0000, a1);
    wait_frames(2);
    check("b2b_done0", 64'(fd_log[0]), 64'(a0 + FRAME_CYC));
    check("b2b_done1", 64'(fd_log[1]), 64'(a0 + 2 * FRAME_CYC));
    @(negedge clk);

    // Backpressure: three words offered continuously.
    reset_logs();
    offer(32'h1234_5678, a0);
    offer(32'h9ABC_DEF0, a1);
    offer(32'hC0FF_EE11, a2);
    check("bp_acc2", 64'(a1), 64'(a0 + 2));
    check("bp_acc3", 64'(a2), 64'(a0 + FRAME_CYC + 2));
    wait_frames(3);
    check("bp_done2", 64'(fd_log[2]), 64'(a0 + 3 * FRAME_CYC));
    check("bp_order", 64'(exp_q.size()), 64'd0);
    @(negedge clk);

    // Accept on the same edge GAP ends with hold empty: one idle cycle between frames.
    reset_logs();
    offer(32'h8000_0001, a0);
    wait_until(a0 + FRAME_CYC);
    offer(32'h7FFF_FFFE, a1);
    wait_frames(2);
    check("gap_edge_done1", 64'(fd_log[1]), 64'(a0 + 2 * FRAME_CYC + 1));
    @(negedge clk);

    // Reset in the middle of DATA bit 10 with a second word waiting.
    reset_logs();
    offer(32'h0000_0000, a0);
    offer(32'hDEAD_BEEF, a1);
    wait_until(a0 + 57);
    check("pre_rst_out", 64'(out), 64'd1);
    check("pre_rst_hold", 64'(bus.in_ready), 64'd0);
    exp_q.delete();
    #2 rst = 1'b1;
    #1;
    check("async_out", 64'(out), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    repeat (10) @(negedge clk);
    check("post_rst_idle", 64'(busy), 64'd0);
    offer(32'h3C3C_A5A5, a0);
    wait_frames(1);
    check("fresh_done", 64'(fd_log[0]), 64'(a0 + FRAME_CYC));
    repeat (4) @(negedge clk);
    check("final_q_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_um_hoene_manchester_encoder.md
Name: tt_um_hoene_manchester_encoder

Overview:
- Transmit end of the LED-chain serial link: takes 32-bit words over a valid/ready handshake and serialises each word as a Manchester-coded frame on a single output pin.
- Frame format: preamble, then data, then a quiet gap. The downstream receive chain (pulse-width measuring decoder, then the sync/counter logic) locks onto this format.
- Sits beside the receive path in the top level and drives a uo_out pin so the next chip in the chain can be fed.

Parameters:
- DATA_WIDTH, 32, payload bits per frame.
- HALF_PERIOD, 8, clk cycles per Manchester half-bit; legal range 2..63.
- PREAMBLE_BITS, 4, number of logical '1' bits sent before the payload.
- GAP_BITS, 2, bit-times of constant low after the payload; marks end of frame.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  DATA_WIDTH  word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  holding register empty; a transfer occurs when in_valid && in_ready at a rising edge.
- out  output  1  Manchester line, registered, idle low.
- busy  output  1  high while a frame is in PREAMBLE, DATA or GAP.
- frame_done  output  1  one-cycle pulse on the last cycle of GAP.

Behaviour:
- Reset (async assert): out=0, busy=0, frame_done=0, in_ready=1. Holding register is emptied and the state is IDLE. A frame in flight is abandoned and out drops low immediately without waiting for a clock edge.
- Coding (IEEE 802.3 convention): logical '1' = low for HALF_PERIOD cycles, then high for HALF_PERIOD cycles. Logical '0' = high then low. Payload is sent MSB first.
- Buffering: a one-entry holding register. in_ready = !hold_valid and is independent of the FSM state, so the next word can be accepted during any state.
- States:
  - IDLE: out=0. If hold_valid at an edge, load the shifter from the holding register, clear hold_valid, go to PREAMBLE, and drive the first half-level in the same edge.
  - PREAMBLE: send PREAMBLE_BITS '1' bits, then go to DATA.
  - DATA: send DATA_WIDTH bits, then go to GAP.
  - GAP: out=0 for GAP_BITS*2*HALF_PERIOD cycles. On the final cycle assert frame_done. Then go to PREAMBLE directly if hold_valid (shifter loaded in the same edge), otherwise go to IDLE.
- Latency: word accepted into an empty IDLE block at edge t → out shows the first preamble half-level from edge t+1.
- Frame length: exactly (PREAMBLE_BITS+DATA_WIDTH+GAP_BITS)*2*HALF_PERIOD cycles.
- Back-to-back frames have zero idle cycles between GAP and the next PREAMBLE.
- Timing counters:
  - Half-bit counter counts 0..HALF_PERIOD-1 and wraps; out toggles to the second half-level at the wrap of the first half.
  - Bit counter width is clog2(max(PREAMBLE_BITS,DATA_WIDTH,GAP_BITS)+1). It is reloaded on every state change and never wraps mid-state.
- busy is high from the PREAMBLE-entry edge through the last GAP cycle.
- Simultaneous events:
  - Accept on the same edge GAP ends with hold empty: the word enters the holding register; the FSM goes to IDLE and starts the frame on the next edge (one idle cycle).
  - in_valid while in_ready=0: ignored; the source must hold its word.
- in_data is sampled only on the accepting edge. Later changes to in_data have no effect on the frame in flight.

Decomposition:
- Package tt_um_hoene_manchester_pkg: state enum (IDLE, PREAMBLE, DATA, GAP), LINE_IDLE=1'b0 constant, and a function returning the half-level for a given bit value and half index. The decoder side should reuse these.
- Sub-module tt_um_hoene_halfbit_timer:
  - Inputs: clk, rst, restart.
  - Outputs: half_tick (last cycle of a half) and second_half flag.
  - Counter width is sized from HALF_PERIOD.

Test Plan:
- Idle after reset (HALF_PERIOD=2): no in_valid for 100 cycles → out=0, busy=0, in_ready=1 throughout.
- Single word 0xA5000001 (HALF_PERIOD=2, defaults otherwise), accepted at edge t:
  - Preamble: out = 0,0,1,1 repeated 4 times starting at t+1.
  - Data: first payload bit '1' gives 0,0,1,1; second bit '0' gives 1,1,0,0.
  - Gap: 8 cycles low, frame_done pulse at cycle t+152, busy falls after it.
- Back-to-back words 0xFFFFFFFF then 0x00000000, second offered during first's DATA:
  - in_ready drops for one cycle after the accept.
  - Second PREAMBLE starts on the edge immediately after frame_done; total 304 cycles.
- Backpressure: three words offered continuously → the third stalls (in_ready=0) until the first frame's GAP ends; all three are transmitted in order.
- Reset mid-DATA (rst high for 1 cycle at bit 10) → out=0 asynchronously, busy=0, hold emptied; the next accepted word sends a complete fresh frame.
- Loopback through the receive-side Manchester decoder with random words, HALF_PERIOD 2..16 → decoded bitstream equals the sent words and the decoder error flag never asserts.
